// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and width helpers for the FIFO write-port burst scheduler.
package fifo_wr_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Source tag is never narrower than one bit, even for a single requester.
  function automatic int id_width(input int n_req);
    return (clog2(n_req) < 1) ? 1 : clog2(n_req);
  endfunction

  localparam int ID_W = id_width(4);

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester bundle plus FIFO write-side port shared by the scheduler and its neighbours.
interface fifo_wr_sched_if
  import fifo_wr_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int TAG_W = id_width(N_REQ);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ*DAT_WIDTH-1:0] req_dat;
  logic [N_REQ-1:0]           req_ready;
  logic                       fifo_wr_req;
  logic [TAG_W+DAT_WIDTH-1:0] fifo_wr_dat;
  logic                       fifo_wr_full;
  logic [ADDR_WIDTH:0]        fifo_wr_used;

  modport master (
    input  req_valid, req_last, req_dat, fifo_wr_full, fifo_wr_used,
    output req_ready, fifo_wr_req, fifo_wr_dat
  );

  modport slave (
    output req_valid, req_last, req_dat, fifo_wr_full, fifo_wr_used,
    input  req_ready, fifo_wr_req, fifo_wr_dat
  );

endinterface

// File: rtl/fifo_wr_sched_rr_pick.sv
// Combinational rotating-priority picker: first valid requester after last_id.
module rr_pick
  import fifo_wr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_id,
  output logic             found,
  output logic [ID_W-1:0]  id
);

  logic [ID_W-1:0] cand [N_REQ];

  // cand[k] is the requester k+1 places after the previous grantee.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = ID_W'((int'(last_id) + 1 + gi) % N_REQ);
  end

  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        found = 1'b1;
        id    = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Burst-level round-robin scheduler sharing one FIFO write port among N_REQ producers.
module fifo_wr_sched
  import fifo_wr_sched_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DAT_WIDTH  = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int MAX_BURST  = 16,
  localparam int TAG_W      = id_width(N_REQ)
) (
  input  logic                  wr_clk,
  input  logic                  wr_sclr,
  fifo_wr_sched_if.master       bus,
  output logic                  busy,
  output logic [TAG_W-1:0]      grant_id,
  output logic [N_REQ-1:0]      burst_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BC_W  = clog2(MAX_BURST + 1);
  localparam logic [ADDR_WIDTH+1:0] ADMIT_MAX = (ADDR_WIDTH + 2)'(DEPTH - MAX_BURST);
  localparam logic [BC_W-1:0]       BEAT_MAX  = BC_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   grant_id_q, grant_id_d;
  logic [TAG_W-1:0]   last_id_q, last_id_d;
  logic [BC_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic               wr_d1_q, wr_d1_d;
  logic [N_REQ-1:0]   burst_err_q, burst_err_d;

  logic               pick_found;
  logic [TAG_W-1:0]   pick_id;
  logic [ADDR_WIDTH+1:0] used_sum;
  logic               admit;
  logic [BC_W-1:0]    beat_inc;
  logic [DAT_WIDTH-1:0] req_word [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign req_word[gi] = bus.req_dat[gi*DAT_WIDTH +: DAT_WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (TAG_W)
  ) u_pick (
    .req_valid (bus.req_valid),
    .last_id   (last_id_q),
    .found     (pick_found),
    .id        (pick_id)
  );

  // wr_d1 accounts for our own write that fifo_wr_used has not yet reflected.
  assign used_sum = {1'b0, bus.fifo_wr_used} + {{(ADDR_WIDTH + 1){1'b0}}, wr_d1_q};
  assign admit    = (used_sum <= ADMIT_MAX);
  assign beat_inc = beat_cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_id_d       = last_id_q;
    beat_cnt_d      = beat_cnt_q;
    burst_err_d     = burst_err_q;
    bus.req_ready   = '0;
    bus.fifo_wr_req = 1'b0;
    bus.fifo_wr_dat = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found && admit) begin
          state_d    = ST_BURST;
          grant_id_d = pick_id;
          last_id_d  = pick_id;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        bus.req_ready[grant_id_q] = !bus.fifo_wr_full;
        bus.fifo_wr_dat           = {grant_id_q, req_word[grant_id_q]};
        if (bus.req_valid[grant_id_q] && !bus.fifo_wr_full) begin
          bus.fifo_wr_req = 1'b1;
          beat_cnt_d      = beat_inc;
          if (bus.req_last[grant_id_q]) begin
            state_d = ST_IDLE;
          end else if (beat_inc == BEAT_MAX) begin
            state_d                  = ST_IDLE;
            burst_err_d[grant_id_q]  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_d1_d = bus.fifo_wr_req;
  end

  always_ff @(posedge wr_clk) begin
    if (wr_sclr) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      last_id_q   <= TAG_W'(N_REQ - 1);
      beat_cnt_q  <= '0;
      wr_d1_q     <= 1'b0;
      burst_err_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_d1_q     <= wr_d1_d;
      burst_err_q <= burst_err_d;
    end
  end

  assign busy      = (state_q == ST_BURST);
  assign grant_id  = grant_id_q;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: queue-driven producers, per-cycle reference model, literal checks.
module tb_fifo_wr_sched;
  import fifo_wr_sched_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int MB    = 16;
  localparam int TW    = id_width(N);
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } word_t;

  logic clk = 1'b0;
  logic sclr;
  logic busy;
  logic [TW-1:0] gid;
  logic [N-1:0]  err;

  always #5 clk = ~clk;

  fifo_wr_sched_if #(.N_REQ(N), .DAT_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_wr_sched #(
    .N_REQ      (N),
    .DAT_WIDTH  (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk    (clk),
    .wr_sclr   (sclr),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (gid),
    .burst_err (err)
  );

  int checks   = 0;
  int failures = 0;

  word_t             src_q [N][$];
  logic [N-1:0]      hold_mask = '0;
  logic [TW+DW-1:0]  got_q [$];
  logic [TW-1:0]     grants [$];
  int                gap_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Producers: each presents the head of its queue; a word leaves on valid & ready.
  initial begin
    logic [N-1:0] acc;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_dat   = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !hold_mask[i]) begin
          bus.req_valid[i]           = 1'b1;
          bus.req_last[i]            = src_q[i][0].last;
          bus.req_dat[i*DW +: DW]    = src_q[i][0].dat;
        end else begin
          bus.req_valid[i]           = 1'b0;
          bus.req_last[i]            = 1'b0;
          bus.req_dat[i*DW +: DW]    = '0;
        end
      end
    end
  end

  // Reference model: owner < 0 means nobody holds the port.
  initial begin
    int m_owner, m_last, m_gid, m_beats, pick, idle_run;
    logic m_prev_wr, prev_busy;
    logic [N-1:0] m_err, e_ready;
    logic e_wr, e_busy;
    logic [TW+DW-1:0] e_dat;
    m_owner = -1; m_last = N - 1; m_gid = 0; m_beats = 0;
    m_prev_wr = 1'b0; m_err = '0; prev_busy = 1'b0; idle_run = 0;
    forever begin
      @(negedge clk);
      e_ready = '0; e_wr = 1'b0; e_dat = '0; e_busy = (m_owner >= 0);
      if (m_owner >= 0) begin
        e_ready[m_owner] = !bus.fifo_wr_full;
        e_wr  = bus.req_valid[m_owner] && !bus.fifo_wr_full;
        e_dat = {TW'(m_owner), bus.req_dat[m_owner*DW +: DW]};
      end
      checks++;
      if (bus.req_ready !== e_ready || bus.fifo_wr_req !== e_wr || busy !== e_busy ||
          gid !== TW'(m_gid) || err !== m_err || (e_wr && bus.fifo_wr_dat !== e_dat)) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual ready=%b wr=%b dat=%h busy=%b gid=%0d err=%b required ready=%b wr=%b dat=%h busy=%b gid=%0d err=%b",
                 $time, bus.req_ready, bus.fifo_wr_req, bus.fifo_wr_dat, busy, gid, err,
                 e_ready, e_wr, e_dat, e_busy, m_gid, m_err);
      end
      if (bus.fifo_wr_req === 1'b1) begin
        got_q.push_back(bus.fifo_wr_dat);
        $display("write t=%0t id=%0d dat=%h", $time, bus.fifo_wr_dat[TW+DW-1:DW], bus.fifo_wr_dat[DW-1:0]);
      end
      if (busy === 1'b1 && !prev_busy) begin
        grants.push_back(gid);
        gap_q.push_back(idle_run);
        idle_run = 0;
      end
      if (busy !== 1'b1) idle_run++;
      prev_busy = (busy === 1'b1);

      if (sclr) begin
        m_owner = -1; m_last = N - 1; m_gid = 0; m_beats = 0;
        m_prev_wr = 1'b0; m_err = '0;
      end else begin
        if (m_owner < 0) begin
          if (bus.req_valid != '0 && (int'(bus.fifo_wr_used) + int'(m_prev_wr) <= DEPTH - MB)) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
              if (pick < 0 && bus.req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
            m_owner = pick; m_last = pick; m_gid = pick; m_beats = 0;
          end
        end else if (e_wr) begin
          m_beats++;
          if (bus.req_last[m_owner]) begin
            m_owner = -1;
          end else if (m_beats == MB) begin
            m_err[m_owner] = 1'b1;
            m_owner = -1;
          end
        end
        m_prev_wr = e_wr;
      end
    end
  end

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int n, input string name);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      nedge();
      k++;
    end
    if (got_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d writes", name, got_q.size(), n);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy !== 1'b0 || src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0) && k < 300) begin
      nedge();
      k++;
    end
    if (k >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout actual=busy%b required=idle", name, busy);
    end
    nedge();
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    word_t w;
    w.last = l;
    w.dat  = d;
    src_q[r].push_back(w);
  endtask

  task automatic pulse_reset();
    pedge(); sclr = 1'b1;
    pedge(); sclr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g0;
    sclr = 1'b1;
    bus.fifo_wr_full = 1'b0;
    bus.fifo_wr_used = '0;
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    nedge();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_gid",   64'(gid), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_wr",    64'(bus.fifo_wr_req), 64'd0);
    chk("rst_dat",   64'(bus.fifo_wr_dat), 64'd0);

    // Single 3-word burst from requester 1.
    base = got_q.size();
    push(1, 32'hA0A0_0001, 1'b0);
    push(1, 32'hB0B0_0002, 1'b0);
    push(1, 32'hC0C0_0003, 1'b1);
    nedge();
    chk("single_req_cycle_busy", 64'(busy), 64'd0);
    nedge();
    chk("single_grant_busy",  64'(busy), 64'd1);
    chk("single_grant_ready", 64'(bus.req_ready), 64'h2);
    wait_writes(base + 3, "single");
    wait_idle("single");
    chk("single_w0", 64'(got_q[base+0]), {30'd0, 2'd1, 32'hA0A0_0001});
    chk("single_w1", 64'(got_q[base+1]), {30'd0, 2'd1, 32'hB0B0_0002});
    chk("single_w2", 64'(got_q[base+2]), {30'd0, 2'd1, 32'hC0C0_0003});
    chk("single_count", 64'(got_q.size()), 64'(base + 3));

    // Round robin between requesters 0 and 2, two 2-word bursts each.
    pulse_reset();
    nedge();
    base = got_q.size();
    g0   = grants.size();
    for (int b = 0; b < 2; b++) begin
      push(0, 32'h0000_0100 + 32'(2*b), 1'b0);
      push(0, 32'h0000_0101 + 32'(2*b), 1'b1);
      push(2, 32'h0000_0200 + 32'(2*b), 1'b0);
      push(2, 32'h0000_0201 + 32'(2*b), 1'b1);
    end
    wait_writes(base + 8, "rr");
    wait_idle("rr");
    chk("rr_grant0", 64'(grants[g0+0]), 64'd0);
    chk("rr_grant1", 64'(grants[g0+1]), 64'd2);
    chk("rr_grant2", 64'(grants[g0+2]), 64'd0);
    chk("rr_grant3", 64'(grants[g0+3]), 64'd2);
    for (int i = 1; i < 4; i++) chk("rr_gap", 64'(gap_q[g0+i]), 64'd1);
    chk("rr_first_word", 64'(got_q[base+0]), {30'd0, 2'd0, 32'h0000_0100});
    chk("rr_third_word", 64'(got_q[base+2]), {30'd0, 2'd2, 32'h0000_0200});

    // Full asserted for four cycles in the middle of a 6-word burst.
    base = got_q.size();
    for (int i = 0; i < 6; i++) push(1, 32'h0D00_0000 + 32'(i), (i == 5));
    wait_writes(base + 2, "stall");
    pedge(); bus.fifo_wr_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nedge();
      chk("stall_wr",    64'(bus.fifo_wr_req), 64'd0);
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_busy",  64'(busy), 64'd1);
    end
    pedge(); bus.fifo_wr_full = 1'b0;
    wait_writes(base + 6, "stall");
    wait_idle("stall");
    chk("stall_count", 64'(got_q.size()), 64'(base + 6));
    for (int i = 0; i < 6; i++)
      chk("stall_word", 64'(got_q[base+i]), {30'd0, 2'd1, 32'h0D00_0000 + 32'(i)});

    // Admission: one word too many in the FIFO blocks the grant.
    pedge(); bus.fifo_wr_used = 9'(DEPTH - MB + 1);
    nedge();
    push(2, 32'h0000_A0D1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("adm_blocked", 64'(busy), 64'd0);
    end
    pedge(); bus.fifo_wr_used = 9'(DEPTH - MB);
    nedge();
    chk("adm_eval_cycle", 64'(busy), 64'd0);
    nedge();
    chk("adm_grant_busy", 64'(busy), 64'd1);
    chk("adm_grant_id",   64'(gid), 64'd2);
    pedge(); bus.fifo_wr_used = '0;
    wait_idle("adm");

    // Runaway burst from requester 3, truncated at MAX_BURST.
    base = got_q.size();
    g0   = grants.size();
    for (int i = 0; i < 20; i++) push(3, 32'h3000_0000 + 32'(i), (i == 19));
    push(0, 32'h0000_00E0, 1'b1);
    push(1, 32'h0000_00E1, 1'b1);
    wait_writes(base + 22, "runaway");
    wait_idle("runaway");
    chk("run_grant0", 64'(grants[g0+0]), 64'd3);
    chk("run_grant1", 64'(grants[g0+1]), 64'd0);
    chk("run_grant2", 64'(grants[g0+2]), 64'd1);
    chk("run_grant3", 64'(grants[g0+3]), 64'd3);
    chk("run_last_of_burst", 64'(got_q[base+15]), {30'd0, 2'd3, 32'h3000_000F});
    chk("run_next_grantee",  64'(got_q[base+16]), {30'd0, 2'd0, 32'h0000_00E0});
    chk("run_err", 64'(err), 64'h8);

    // Reset after 2 of 5 words.
    base = got_q.size();
    for (int i = 0; i < 5; i++) push(1, 32'h5000_0000 + 32'(i), (i == 4));
    wait_writes(base + 2, "rstmid");
    hold_mask[1] = 1'b1;
    pedge(); sclr = 1'b1;
    pedge(); sclr = 1'b0;
    nedge();
    chk("rstmid_busy",  64'(busy), 64'd0);
    chk("rstmid_gid",   64'(gid), 64'd0);
    chk("rstmid_err",   64'(err), 64'd0);
    chk("rstmid_ready", 64'(bus.req_ready), 64'd0);
    chk("rstmid_wr",    64'(bus.fifo_wr_req), 64'd0);
    chk("rstmid_dat",   64'(bus.fifo_wr_dat), 64'd0);
    chk("rstmid_count", 64'(got_q.size()), 64'(base + 2));
    src_q[1].delete();
    g0 = grants.size();
    push(1, 32'h0000_00F1, 1'b1);
    push(0, 32'h0000_00F0, 1'b1);
    hold_mask[1] = 1'b0;
    wait_writes(base + 4, "rstmid");
    wait_idle("rstmid");
    chk("rstmid_grant0", 64'(grants[g0+0]), 64'd0);
    chk("rstmid_grant1", 64'(grants[g0+1]), 64'd1);
    chk("rstmid_w0", 64'(got_q[base+2]), {30'd0, 2'd0, 32'h0000_00F0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
